// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: shares one byte-wide memory port between the HPS download stream
// and the game CPU, and owns the game core reset.
module rom_load_ctrl #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned REGION_SHIFT = 14,
  parameter int unsigned REGION_CNT   = 6,
  parameter int unsigned RESET_HOLD   = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  output logic              core_reset,
  output logic              load_err
);

  localparam int unsigned RegW  = ADDR_W - REGION_SHIFT;
  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [RegW:0]      RegLim   = (RegW + 1)'(REGION_CNT);
  localparam logic [HoldW-1:0]   HoldLast = HoldW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StLoading, StHold, StRun} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W:0]   r_byte_cnt;
  logic [HoldW-1:0]  r_hold_cnt;
  logic              r_core_reset;
  logic              r_load_err;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_din;
  logic [7:0]        r_cpu_data;
  logic              r_cpu_valid;
  logic              r_rd_pend;
  logic              r_rd_wait;

  logic w_wr_req;
  logic w_in_range;
  logic w_wr_ok;
  logic w_wr_bad;
  logic w_enter_load;
  logic w_stay_run;
  logic w_busy;
  logic w_rd_accept;

  always_comb begin
    w_wr_req     = (r_state == StLoading) && dn_wr;
    w_in_range   = {1'b0, dn_addr[ADDR_W-1:REGION_SHIFT]} < RegLim;
    w_wr_ok      = w_wr_req && w_in_range;
    w_wr_bad     = w_wr_req && !w_in_range;
    w_busy       = (r_state != StRun) || r_rd_pend || r_rd_wait;

    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (dn_download) w_state_d = StLoading;
      // A write in the falling cycle still counts towards a non-empty download.
      StLoading: if (!dn_download) begin
        w_state_d = ((r_byte_cnt != '0) || w_wr_ok) ? StHold : StIdle;
      end
      StHold: begin
        if (dn_download)                  w_state_d = StLoading;
        else if (r_hold_cnt == HoldLast)  w_state_d = StRun;
      end
      StRun:     if (dn_download) w_state_d = StLoading;
      default:   w_state_d = StIdle;
    endcase

    w_enter_load = (r_state != StLoading) && (w_state_d == StLoading);
    w_stay_run   = (r_state == StRun) && (w_state_d == StRun);
    w_rd_accept  = w_stay_run && !w_busy && cpu_rd;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_byte_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_load_err   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_cpu_data   <= '0;
      r_cpu_valid  <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_wait    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_core_reset <= (w_state_d != StRun);

      if (w_enter_load)                         r_byte_cnt <= '0;
      else if (w_wr_ok && (r_byte_cnt != '1))   r_byte_cnt <= r_byte_cnt + 1'b1;

      if (w_enter_load)   r_load_err <= 1'b0;
      else if (w_wr_bad)  r_load_err <= 1'b1;

      if ((r_state == StHold) && (w_state_d == StHold)) r_hold_cnt <= r_hold_cnt + 1'b1;
      else                                              r_hold_cnt <= '0;

      r_mem_we <= w_wr_ok;
      if (w_wr_ok) begin
        r_mem_addr <= dn_addr;
        r_mem_din  <= dn_data;
      end else if (w_rd_accept) begin
        r_mem_addr <= cpu_addr;
      end

      // Any exit from RUN drops the read pipeline, abandoning an outstanding read.
      r_rd_pend   <= w_rd_accept;
      r_rd_wait   <= r_rd_pend && w_stay_run;
      r_cpu_valid <= r_rd_wait && w_stay_run;
      if (r_rd_wait && w_stay_run) r_cpu_data <= mem_dout;
    end
  end

  assign cpu_data   = r_cpu_data;
  assign cpu_valid  = r_cpu_valid;
  assign cpu_busy   = w_busy;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_we     = r_mem_we;
  assign core_reset = r_core_reset;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: vector table for load sequencing, hand sequences for reads,
// range errors, empty downloads, download pre-emption and async reset.
module tb_rom_load_ctrl;

  localparam int unsigned AW   = 17;
  localparam int unsigned HOLD = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dn_download, dn_wr, cpu_rd;
  logic [AW-1:0] dn_addr, cpu_addr, mem_addr;
  logic [7:0]    dn_data, cpu_data, mem_din, mem_dout;
  logic          cpu_valid, cpu_busy, mem_we, core_reset, load_err;

  rom_load_ctrl #(.ADDR_W(AW), .REGION_SHIFT(14), .REGION_CNT(6), .RESET_HOLD(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_valid(cpu_valid), .cpu_busy(cpu_busy), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout), .core_reset(core_reset),
    .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  int n_pass = 0;
  int n_total = 0;
  logic [AW+7:0] wr_q[$];
  logic [7:0]    rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Scoreboard side: every mem_we / cpu_valid must match an expectation queued at stimulus time.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (mem_we) begin
        if (wr_q.size() == 0) chk("unexpected_mem_we", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          logic [AW+7:0] e;
          e = wr_q.pop_front();
          chk("mem_wr_addr", 32'(mem_addr), 32'(e[AW+7:8]));
          chk("mem_wr_data", 32'(mem_din), 32'(e[7:0]));
        end
      end
      if (cpu_valid) begin
        if (rd_q.size() == 0) chk("unexpected_cpu_valid", 32'(cpu_data), 32'hFFFF_FFFF);
        else chk("cpu_rd_data", 32'(cpu_data), 32'(rd_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic          dl, wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          rd;
    logic [AW-1:0] ra;
    logic          e_cr, e_busy, e_we, e_err, e_valid;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_run();
    int n = 0;
    while (core_reset && n < 200) begin
      step();
      n++;
    end
    chk("reach_run", 32'(core_reset), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen_low;
    //          dl    wr    addr    data   rd    raddr  cr    busy  we    err   valid
    vecs[0] = '{1'b0, 1'b0, 17'h0, 8'h00, 1'b1, 17'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 17'h0, 8'h00, 1'b1, 17'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 17'h0, 8'h77, 1'b0, 17'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 17'h0, 8'hAA, 1'b0, 17'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 17'h1, 8'hBB, 1'b0, 17'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 17'h2, 8'hCC, 1'b0, 17'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 17'h3, 8'hDD, 1'b0, 17'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; dn_download = 0; dn_wr = 0; dn_addr = '0; dn_data = '0;
    cpu_rd = 0; cpu_addr = '0;
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_cpu_busy", 32'(cpu_busy), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk_sys); @(negedge clk_sys);
    reset = 1'b0;
    #4;

    // Idle reads are ignored; wr in the dn_download rising cycle is dropped; last wr lands.
    for (int i = 0; i < 7; i++) begin
      dn_download = vecs[i].dl; dn_wr = vecs[i].wr; dn_addr = vecs[i].a; dn_data = vecs[i].d;
      cpu_rd = vecs[i].rd; cpu_addr = vecs[i].ra;
      if (vecs[i].e_we) wr_q.push_back({vecs[i].a, vecs[i].d});
      step();
      chk($sformatf("v%0d_core_reset", i), 32'(core_reset), 32'(vecs[i].e_cr));
      chk($sformatf("v%0d_cpu_busy", i), 32'(cpu_busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_load_err", i), 32'(load_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_cpu_valid", i), 32'(cpu_valid), 32'(vecs[i].e_valid));
    end
    dn_wr = 0; cpu_rd = 0;

    // core_reset must fall exactly HOLD+1 edges after dn_download fell.
    n = 1;
    while (core_reset && n < 200) begin
      step();
      n++;
    end
    chk("hold_cycles", 32'(n), 32'(HOLD + 1));
    chk("run_not_busy", 32'(cpu_busy), 32'd0);

    // Three-cycle CPU read.
    cpu_rd = 1; cpu_addr = 17'h2; rd_q.push_back(8'hCC);
    step();
    cpu_rd = 0;
    chk("rd_c1_busy", 32'(cpu_busy), 32'd1);
    chk("rd_c1_addr", 32'(mem_addr), 32'h2);
    chk("rd_c1_we", 32'(mem_we), 32'd0);
    step();
    chk("rd_c2_busy", 32'(cpu_busy), 32'd1);
    chk("rd_c2_valid", 32'(cpu_valid), 32'd0);
    step();
    chk("rd_c3_valid", 32'(cpu_valid), 32'd1);
    chk("rd_c3_data", 32'(cpu_data), 32'hCC);
    chk("rd_c3_busy", 32'(cpu_busy), 32'd0);
    step();
    cpu_rd = 1; cpu_addr = 17'h0; rd_q.push_back(8'hAA);
    step(); cpu_rd = 0;
    step(); step();
    chk("rd2_valid", 32'(cpu_valid), 32'd1);
    chk("rd2_data", 32'(cpu_data), 32'hAA);

    // Region range check and sticky load_err.
    dn_download = 1; step();
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    dn_wr = 1; dn_addr = 17'h18000; dn_data = 8'h5A; step();
    chk("oor_mem_we", 32'(mem_we), 32'd0);
    chk("oor_load_err", 32'(load_err), 32'd1);
    dn_addr = 17'h17FFF; dn_data = 8'hE7; wr_q.push_back({17'h17FFF, 8'hE7}); step();
    chk("edge_mem_we", 32'(mem_we), 32'd1);
    dn_wr = 0; dn_download = 0; step();
    chk("err_sticky", 32'(load_err), 32'd1);
    dn_download = 1; step();
    chk("err_cleared", 32'(load_err), 32'd0);

    // Empty download returns to IDLE and keeps the core in reset.
    dn_download = 0;
    seen_low = 0;
    for (int i = 0; i < HOLD + 6; i++) begin
      step();
      if (!core_reset) seen_low = 1;
    end
    chk("empty_keeps_reset", 32'(seen_low), 32'd0);
    chk("empty_busy", 32'(cpu_busy), 32'd1);

    // Back to RUN with a two-byte download.
    dn_download = 1; step();
    dn_wr = 1; dn_addr = 17'h0; dn_data = 8'h11; wr_q.push_back({17'h0, 8'h11}); step();
    dn_addr = 17'h1; dn_data = 8'h22; wr_q.push_back({17'h1, 8'h22}); step();
    dn_wr = 0; dn_download = 0; step();
    wait_run();

    // Download pre-empts an outstanding read.
    cpu_rd = 1; cpu_addr = 17'h1; step();
    cpu_rd = 0; dn_download = 1; step();
    chk("preempt_core_reset", 32'(core_reset), 32'd1);
    chk("preempt_busy", 32'(cpu_busy), 32'd1);
    dn_wr = 1; dn_addr = 17'h4; dn_data = 8'hEE; wr_q.push_back({17'h4, 8'hEE}); step();
    chk("preempt_wr_we", 32'(mem_we), 32'd1);
    dn_wr = 0; step(); step();
    chk("preempt_no_valid", 32'(cpu_valid), 32'd0);
    chk("preempt_data_held", 32'(cpu_data), 32'hAA);

    // Async reset mid-download, between clock edges.
    dn_wr = 1; dn_addr = 17'h5; dn_data = 8'h55;
    #2 reset = 1'b1;
    #1;
    chk("arst_core_reset", 32'(core_reset), 32'd1);
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_mem_din", 32'(mem_din), 32'd0);
    chk("arst_cpu_data", 32'(cpu_data), 32'd0);
    chk("arst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("arst_cpu_busy", 32'(cpu_busy), 32'd1);
    chk("arst_load_err", 32'(load_err), 32'd0);
    dn_wr = 0; dn_download = 0;
    @(negedge clk_sys); reset = 1'b0;
    step(); step();
    chk("post_rst_core_reset", 32'(core_reset), 32'd1);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
